// File: rtl/serial_to_parallel_rx_if.sv
// Serial receive link bundle: one serial input bit and the byte-rate outputs.
// The slave modport is the receiver side; the master side drives data_in and observes bytes.
interface serial_to_parallel_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Comma-aligned 1-bit deserializer with lock detection, feeding the byte-rate demux.
// Optional feature macro SP_LOSS_DETECT_EN: drop lock after more than MAX_GAP non-comma bytes.
module serial_to_parallel_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_GAP    = 16
) (
  input  logic                    clk,
  input  logic                    reset_L,
  serial_to_parallel_rx_if.slave  link
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT = LOCK_COUNT[3:0];

  if (LOCK_COUNT < 2 || LOCK_COUNT > 15) begin : g_bad_lock_count
    $error("LOCK_COUNT out of range 2..15");
  end
  if (MAX_GAP < 1 || MAX_GAP > 255) begin : g_bad_max_gap
    $error("MAX_GAP out of range 1..255");
  end

  state_t     state_reg;
  // Only the seven most recent bits are needed to form the candidate byte.
  logic [6:0] sr_reg;
  logic [2:0] bit_cnt_reg;
  logic [3:0] cc_reg;
  logic [7:0] data_out_reg;
  logic       valid_out_reg;
  logic       byte_strobe_reg;
  logic       active_reg;

  logic [7:0] nb;
  logic       boundary;

  assign nb       = {sr_reg, link.data_in};
  assign boundary = (bit_cnt_reg == 3'd7);

`ifdef SP_LOSS_DETECT_EN
  localparam logic [7:0] GAP_LIMIT = MAX_GAP[7:0];
  logic [7:0] gap_reg;
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_reg       <= SEARCH;
      sr_reg          <= '0;
      bit_cnt_reg     <= '0;
      cc_reg          <= '0;
      data_out_reg    <= 8'h00;
      valid_out_reg   <= 1'b0;
      byte_strobe_reg <= 1'b0;
      active_reg      <= 1'b0;
`ifdef SP_LOSS_DETECT_EN
      gap_reg         <= '0;
`endif
    end else begin
      sr_reg          <= nb[6:0];
      bit_cnt_reg     <= bit_cnt_reg + 3'd1;
      byte_strobe_reg <= 1'b0;
      case (state_reg)
        SEARCH: begin
          // Bit-sliding: any bit position may start the first comma.
          if (nb == COMMA) begin
            bit_cnt_reg <= 3'd0;
            cc_reg      <= 4'd1;
            state_reg   <= ALIGN;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (nb == COMMA) begin
              cc_reg <= cc_reg + 4'd1;
              if (cc_reg + 4'd1 == LOCK_CNT) begin
                state_reg  <= LOCKED;
                active_reg <= 1'b1;
              end
            end else begin
              state_reg <= SEARCH;
              cc_reg    <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (nb == COMMA) begin
              byte_strobe_reg <= 1'b1;
              data_out_reg    <= 8'h00;
              valid_out_reg   <= 1'b0;
`ifdef SP_LOSS_DETECT_EN
              gap_reg         <= '0;
`endif
            end else begin
`ifdef SP_LOSS_DETECT_EN
              // The byte that would push the gap past the limit is discarded.
              if (gap_reg >= GAP_LIMIT) begin
                state_reg     <= SEARCH;
                active_reg    <= 1'b0;
                data_out_reg  <= 8'h00;
                valid_out_reg <= 1'b0;
                cc_reg        <= 4'd0;
                gap_reg       <= '0;
              end else begin
                gap_reg         <= gap_reg + 8'd1;
                byte_strobe_reg <= 1'b1;
                data_out_reg    <= nb;
                valid_out_reg   <= 1'b1;
              end
`else
              byte_strobe_reg <= 1'b1;
              data_out_reg    <= nb;
              valid_out_reg   <= 1'b1;
`endif
            end
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

  assign link.data_out    = data_out_reg;
  assign link.valid_out   = valid_out_reg;
  assign link.byte_strobe = byte_strobe_reg;
  assign link.active      = active_reg;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: reset, lock, abort, idle commas, gap loss, mid-run reset.
// Honors SP_LOSS_DETECT_EN to select the expected loss-of-lock behaviour.
module tb_serial_to_parallel_rx;

`ifdef SP_LOSS_DETECT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_to_parallel_rx_if link_if ();

  serial_to_parallel_rx #(
    .COMMA      (8'hBC),
    .LOCK_COUNT (4),
    .MAX_GAP    (16)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .link    (link_if.slave)
  );

  always #5 clk = ~clk;

  // Drive one bit, then land 1 ns after the edge that captured it.
  task automatic send_bit(input logic b);
    link_if.data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    link_if.data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    link_if.data_in = 1'b0;
    #1;
    obs = {link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active};
    checks++;
    if (obs !== 11'h0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", obs, 11'h0);
    end
    for (int c = 0; c < 10; c++) begin
      link_if.data_in = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      obs = {link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active};
      checks++;
      if (obs !== 11'h0) begin
        errors++;
        $display("FAIL reset_held cycle %0d: got %h expected %h", c, obs, 11'h0);
      end
    end
    reset_L = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'h55);
      obs = {link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active};
      checks++;
      if (obs !== 11'h0) begin
        errors++;
        $display("FAIL reset_no_comma byte %0d: got %h expected %h", k, obs, 11'h0);
      end
      $display("reset: no-comma byte %0d outputs %h", k, obs);
    end
  endtask

  task automatic test_lock_payload();
    logic [7:0] pay;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'hBC);
      checks++;
      if (link_if.active !== (k == 4)) begin
        errors++;
        $display("FAIL lock_active comma %0d: got %b expected %b", k, link_if.active, (k == 4));
      end
    end
    checks++;
    if ({link_if.valid_out, link_if.byte_strobe} !== 2'b00) begin
      errors++;
      $display("FAIL lock_quiet: got valid/strobe %b expected 00",
               {link_if.valid_out, link_if.byte_strobe});
    end
    send_byte(8'hA5);
    checks++;
    if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe} !== {8'hA5, 2'b11}) begin
      errors++;
      $display("FAIL lock_first_byte: got %h/%b/%b expected a5/1/1",
               link_if.data_out, link_if.valid_out, link_if.byte_strobe);
    end
    $display("lock: active=%b first byte %h", link_if.active, link_if.data_out);
    // Walk 3C bit by bit to see A5 held with the strobe already gone.
    pay = 8'h3C;
    for (int i = 7; i >= 1; i--) begin
      send_bit(pay[i]);
      checks++;
      if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe} !== {8'hA5, 2'b10}) begin
        errors++;
        $display("FAIL lock_hold bit %0d: got %h/%b/%b expected a5/1/0",
                 i, link_if.data_out, link_if.valid_out, link_if.byte_strobe);
      end
    end
    send_bit(pay[0]);
    checks++;
    if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe} !== {8'h3C, 2'b11}) begin
      errors++;
      $display("FAIL lock_second_byte: got %h/%b/%b expected 3c/1/1",
               link_if.data_out, link_if.valid_out, link_if.byte_strobe);
    end
    $display("lock: second byte %h", link_if.data_out);
  endtask

  task automatic test_idle_commas();
    logic [7:0] bytes [3] = '{8'hA5, 8'hBC, 8'h7E};
    logic [7:0] exp_d [3] = '{8'hA5, 8'h00, 8'h7E};
    logic       exp_v [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      send_byte(bytes[k]);
      checks++;
      if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe} !== {exp_d[k], exp_v[k], 1'b1}) begin
        errors++;
        $display("FAIL idle_comma byte %0d: got %h/%b/%b expected %h/%b/1",
                 k, link_if.data_out, link_if.valid_out, link_if.byte_strobe, exp_d[k], exp_v[k]);
      end
      $display("idle: in %h -> data %h valid %b", bytes[k], link_if.data_out, link_if.valid_out);
    end
  endtask

  task automatic test_gap_loss();
    logic [7:0] b;
    logic       dropped;
    send_byte(8'hBC);
    for (int k = 1; k <= 17; k++) begin
      b = 8'(k);
      send_byte(b);
      dropped = LOSS_EN && (k == 17);
      checks++;
      if (dropped) begin
        if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active} !== 11'h0) begin
          errors++;
          $display("FAIL gap_loss byte %0d: got %h/%b/%b/%b expected 00/0/0/0", k,
                   link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active);
        end
      end else if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active} !== {b, 3'b111}) begin
        errors++;
        $display("FAIL gap_byte %0d: got %h/%b/%b/%b expected %h/1/1/1", k,
                 link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active, b);
      end
      $display("gap: byte %0d data %h valid %b active %b", k, link_if.data_out,
               link_if.valid_out, link_if.active);
    end
  endtask

  task automatic test_aborted_align();
    logic [7:0] seq [8] = '{8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      send_byte(seq[k]);
      checks++;
      if (link_if.active !== (k == 6)) begin
        errors++;
        $display("FAIL abort_active byte %0d: got %b expected %b", k, link_if.active, (k == 6));
      end
    end
    send_byte(seq[7]);
    checks++;
    if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe} !== {8'h11, 2'b11}) begin
      errors++;
      $display("FAIL abort_payload: got %h/%b/%b expected 11/1/1",
               link_if.data_out, link_if.valid_out, link_if.byte_strobe);
    end
    $display("abort: relocked, payload %h", link_if.data_out);
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) send_byte(8'hBC);
    send_byte(8'hA5);
    checks++;
    if ({link_if.data_out, link_if.valid_out, link_if.active} !== {8'hA5, 2'b11}) begin
      errors++;
      $display("FAIL mid_pre: got %h/%b/%b expected a5/1/1",
               link_if.data_out, link_if.valid_out, link_if.active);
    end
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active} !== 11'h0) begin
      errors++;
      $display("FAIL mid_async_clear: got %h/%b/%b/%b expected 00/0/0/0",
               link_if.data_out, link_if.valid_out, link_if.byte_strobe, link_if.active);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'hBC);
      checks++;
      if (link_if.active !== (k == 4)) begin
        errors++;
        $display("FAIL mid_relock comma %0d: got %b expected %b", k, link_if.active, (k == 4));
      end
    end
    send_byte(8'h3C);
    checks++;
    if ({link_if.data_out, link_if.valid_out, link_if.byte_strobe} !== {8'h3C, 2'b11}) begin
      errors++;
      $display("FAIL mid_payload: got %h/%b/%b expected 3c/1/1",
               link_if.data_out, link_if.valid_out, link_if.byte_strobe);
    end
    $display("mid-reset: relocked, payload %h", link_if.data_out);
  endtask

  initial begin
    test_reset();
    test_lock_payload();
    test_idle_commas();
    test_gap_loss();
    test_aborted_align();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
